// File: rtl/ddr_chk_pkg.sv
// Shared types and helpers for the multi-channel DDR sequence checker.
package ddr_chk_pkg;

  // Per-lane lock state: HUNT waits for a word to seed the expectation, LOCK checks it.
  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_LOCK = 1'b1
  } lane_state_e;

  // Default number of consecutive mismatches that drop a lane out of LOCK.
  localparam int LOSS_THR_DEF = 4;

  // Widest counter the saturation helper handles.
  localparam int SAT_WD = 64;

  // Width of a run counter that must be able to hold loss_thr itself.
  function automatic int run_wd(input int loss_thr);
    return $clog2(loss_thr + 1);
  endfunction

  // Increment val, holding at the all-ones value of a wd-bit counter.
  function automatic logic [SAT_WD-1:0] sat_inc(input logic [SAT_WD-1:0] val,
                                                input int unsigned       wd);
    logic [SAT_WD-1:0] max_val;
    if (wd >= SAT_WD) max_val = '1;
    else              max_val = (SAT_WD'(1) << wd) - SAT_WD'(1);
    return (val >= max_val) ? val : val + SAT_WD'(1);
  endfunction

endpackage

// File: rtl/ddr_seq_chk_lane.sv
// One checker channel: lock FSM, expected-sequence register, mismatch run
// counter and saturating good/bad word counters.
import ddr_chk_pkg::*;

module ddr_seq_chk_lane #(
  parameter int DATA_WD  = 64,
  parameter int SEQ_LSB  = 0,
  parameter int SEQ_WD   = 16,
  parameter int CNT_WD   = 32,
  parameter int LOSS_THR = LOSS_THR_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              resync,
  input  logic              vld,
  input  logic [DATA_WD-1:0] data,
  output logic [CNT_WD-1:0] suc_cnt,
  output logic [CNT_WD-1:0] err_cnt,
  output logic              lock,
  output logic              mis,
  output logic [SEQ_WD-1:0] exp_seq,
  output logic [SEQ_WD-1:0] rcv_seq
);

  localparam int RUN_WD = run_wd(LOSS_THR);

  lane_state_e       state;
  logic [SEQ_WD-1:0] exp_q;
  logic [RUN_WD-1:0] run;
  logic [RUN_WD-1:0] run_nxt;
  logic              data_unused;

  // Only the sequence field is checked; the payload around it is ignored.
  assign rcv_seq     = data[SEQ_LSB +: SEQ_WD];
  assign data_unused = ^data;
  assign exp_seq     = exp_q;
  assign run_nxt     = RUN_WD'(sat_inc(SAT_WD'(run), RUN_WD));

  // Mismatch seen this cycle; feeds the shared first-error capture.
  assign mis = vld && !clr && (state == ST_LOCK) && (rcv_seq != exp_q);

  // Lock FSM with its expected value, run counter and word counters.
  always_ff @(posedge clk) begin
    // NOTE: synchronous reset; cfg_rst shares the branch so a vld in the same cycle is dropped.
    if (!rst_n || clr) begin
      state   <= ST_HUNT;
      lock    <= 1'b0;
      exp_q   <= '0;
      run     <= '0;
      suc_cnt <= '0;
      err_cnt <= '0;
    end else if (vld) begin
      // NOTE: non-blocking so every register updates from the same pre-edge values.
      case (state)
        ST_HUNT: begin
          exp_q <= rcv_seq + SEQ_WD'(1);
          run   <= '0;
          state <= ST_LOCK;
          lock  <= 1'b1;
        end
        ST_LOCK: begin
          if (rcv_seq == exp_q) begin
            suc_cnt <= CNT_WD'(sat_inc(SAT_WD'(suc_cnt), CNT_WD));
            exp_q   <= exp_q + SEQ_WD'(1);
            run     <= '0;
          end else begin
            err_cnt <= CNT_WD'(sat_inc(SAT_WD'(err_cnt), CNT_WD));
            exp_q   <= resync ? rcv_seq + SEQ_WD'(1) : exp_q + SEQ_WD'(1);
            if (run_nxt == RUN_WD'(LOSS_THR)) begin
              state <= ST_HUNT;
              lock  <= 1'b0;
              run   <= '0;
            end else begin
              run <= run_nxt;
            end
          end
        end
        default: begin
          state <= ST_HUNT;
          lock  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/ddr_seq_chk_mc.sv
// Multi-channel sequence checker: per-channel lanes plus a shared sticky
// capture of the first mismatch, lowest channel index winning ties.
import ddr_chk_pkg::*;

module ddr_seq_chk_mc #(
  parameter int CH_NUM   = 4,
  parameter int DATA_WD  = 64,
  parameter int SEQ_LSB  = 0,
  parameter int SEQ_WD   = 16,
  parameter int CNT_WD   = 32,
  parameter int LOSS_THR = LOSS_THR_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_rst,
  input  logic                     cfg_resync,
  input  logic [CH_NUM-1:0]        enc_vld,
  input  logic [CH_NUM*DATA_WD-1:0] enc_data,
  output logic [CH_NUM*CNT_WD-1:0] suc_cnt,
  output logic [CH_NUM*CNT_WD-1:0] err_cnt,
  output logic [CH_NUM-1:0]        lock,
  output logic                     first_err_vld,
  output logic [3:0]               first_err_ch,
  output logic [SEQ_WD-1:0]        first_err_exp,
  output logic [SEQ_WD-1:0]        first_err_rcv
);

  logic [CH_NUM-1:0] lane_mis;
  logic [SEQ_WD-1:0] lane_exp [CH_NUM];
  logic [SEQ_WD-1:0] lane_rcv [CH_NUM];

  logic              any_mis;
  logic [3:0]        sel_ch;
  logic [SEQ_WD-1:0] sel_exp;
  logic [SEQ_WD-1:0] sel_rcv;

  genvar gi;
  generate
    for (gi = 0; gi < CH_NUM; gi++) begin : g_lane
      ddr_seq_chk_lane #(
        .DATA_WD  (DATA_WD),
        .SEQ_LSB  (SEQ_LSB),
        .SEQ_WD   (SEQ_WD),
        .CNT_WD   (CNT_WD),
        .LOSS_THR (LOSS_THR)
      ) u_lane (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (cfg_rst),
        .resync  (cfg_resync),
        .vld     (enc_vld[gi]),
        .data    (enc_data[gi*DATA_WD +: DATA_WD]),
        .suc_cnt (suc_cnt[gi*CNT_WD +: CNT_WD]),
        .err_cnt (err_cnt[gi*CNT_WD +: CNT_WD]),
        .lock    (lock[gi]),
        .mis     (lane_mis[gi]),
        .exp_seq (lane_exp[gi]),
        .rcv_seq (lane_rcv[gi])
      );
    end
  endgenerate

  // Priority-encode this cycle's mismatches; scanning downward leaves the lowest index.
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latch).
    any_mis = 1'b0;
    sel_ch  = '0;
    sel_exp = '0;
    sel_rcv = '0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (lane_mis[i]) begin
        any_mis = 1'b1;
        sel_ch  = 4'(i);
        sel_exp = lane_exp[i];
        sel_rcv = lane_rcv[i];
      end
    end
  end

  // Sticky first-error capture, held until reset or cfg_rst.
  always_ff @(posedge clk) begin
    if (!rst_n || cfg_rst) begin
      first_err_vld <= 1'b0;
      first_err_ch  <= '0;
      first_err_exp <= '0;
      first_err_rcv <= '0;
    end else if (!first_err_vld && any_mis) begin
      first_err_vld <= 1'b1;
      first_err_ch  <= sel_ch;
      first_err_exp <= sel_exp;
      first_err_rcv <= sel_rcv;
    end
  end

endmodule

// File: tb/tb_ddr_seq_chk_mc.sv
// Scoreboard bench for ddr_seq_chk_mc: a behavioural model predicts every
// output snapshot when stimulus is driven; the snapshot is compared one edge later.
module tb_ddr_seq_chk_mc;

  localparam int CH_NUM   = 4;
  localparam int DATA_WD  = 64;
  localparam int SEQ_LSB  = 4;
  localparam int SEQ_WD   = 16;
  localparam int CNT_WD   = 4;
  localparam int LOSS_THR = 4;
  localparam int CNT_MAX  = (1 << CNT_WD) - 1;

  logic                      clk;
  logic                      rst_n;
  logic                      cfg_rst;
  logic                      cfg_resync;
  logic [CH_NUM-1:0]         enc_vld;
  logic [CH_NUM*DATA_WD-1:0] enc_data;
  logic [CH_NUM*CNT_WD-1:0]  suc_cnt;
  logic [CH_NUM*CNT_WD-1:0]  err_cnt;
  logic [CH_NUM-1:0]         lock;
  logic                      first_err_vld;
  logic [3:0]                first_err_ch;
  logic [SEQ_WD-1:0]         first_err_exp;
  logic [SEQ_WD-1:0]         first_err_rcv;

  typedef struct packed {
    logic [CH_NUM-1:0][CNT_WD-1:0] suc;
    logic [CH_NUM-1:0][CNT_WD-1:0] err;
    logic [CH_NUM-1:0]             lock;
    logic                          fe_vld;
    logic [3:0]                    fe_ch;
    logic [SEQ_WD-1:0]             fe_exp;
    logic [SEQ_WD-1:0]             fe_rcv;
  } snap_t;

  snap_t sb_q[$];

  // Reference model state.
  bit                m_lock [CH_NUM];
  logic [SEQ_WD-1:0] m_exp  [CH_NUM];
  int                m_run  [CH_NUM];
  int                m_suc  [CH_NUM];
  int                m_err  [CH_NUM];
  bit                m_fe_vld;
  int                m_fe_ch;
  logic [SEQ_WD-1:0] m_fe_exp;
  logic [SEQ_WD-1:0] m_fe_rcv;

  int checks;
  int errors;

  ddr_seq_chk_mc #(
    .CH_NUM   (CH_NUM),
    .DATA_WD  (DATA_WD),
    .SEQ_LSB  (SEQ_LSB),
    .SEQ_WD   (SEQ_WD),
    .CNT_WD   (CNT_WD),
    .LOSS_THR (LOSS_THR)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_rst       (cfg_rst),
    .cfg_resync    (cfg_resync),
    .enc_vld       (enc_vld),
    .enc_data      (enc_data),
    .suc_cnt       (suc_cnt),
    .err_cnt       (err_cnt),
    .lock          (lock),
    .first_err_vld (first_err_vld),
    .first_err_ch  (first_err_ch),
    .first_err_exp (first_err_exp),
    .first_err_rcv (first_err_rcv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [CNT_WD-1:0] suc_of(input int ch);
    return suc_cnt[ch*CNT_WD +: CNT_WD];
  endfunction

  function automatic logic [CNT_WD-1:0] err_of(input int ch);
    return err_cnt[ch*CNT_WD +: CNT_WD];
  endfunction

  task automatic model_clear();
    for (int ch = 0; ch < CH_NUM; ch++) begin
      m_lock[ch] = 1'b0;
      m_exp[ch]  = '0;
      m_run[ch]  = 0;
      m_suc[ch]  = 0;
      m_err[ch]  = 0;
    end
    m_fe_vld = 1'b0;
    m_fe_ch  = 0;
    m_fe_exp = '0;
    m_fe_rcv = '0;
  endtask

  // Drive one cycle, predict the outcome, then compare the DUT snapshot against the queue head.
  task automatic cycle(input logic [CH_NUM-1:0] vld,
                       input logic [CH_NUM-1:0][SEQ_WD-1:0] seq,
                       input logic clr);
    snap_t             e;
    snap_t             got;
    bit                found;
    logic [DATA_WD-1:0] word;

    cfg_rst = clr;
    enc_vld = vld;
    for (int ch = 0; ch < CH_NUM; ch++) begin
      word = {$urandom, $urandom};
      word[SEQ_LSB +: SEQ_WD] = seq[ch];
      enc_data[ch*DATA_WD +: DATA_WD] = word;
    end

    if (clr) begin
      model_clear();
    end else begin
      found = 1'b0;
      for (int ch = 0; ch < CH_NUM; ch++) begin
        if (vld[ch]) begin
          if (!m_lock[ch]) begin
            m_exp[ch]  = seq[ch] + SEQ_WD'(1);
            m_lock[ch] = 1'b1;
            m_run[ch]  = 0;
          end else if (seq[ch] == m_exp[ch]) begin
            if (m_suc[ch] < CNT_MAX) m_suc[ch]++;
            m_exp[ch] = m_exp[ch] + SEQ_WD'(1);
            m_run[ch] = 0;
          end else begin
            if (m_err[ch] < CNT_MAX) m_err[ch]++;
            if (!m_fe_vld && !found) begin
              found    = 1'b1;
              m_fe_ch  = ch;
              m_fe_exp = m_exp[ch];
              m_fe_rcv = seq[ch];
            end
            m_exp[ch] = cfg_resync ? seq[ch] + SEQ_WD'(1) : m_exp[ch] + SEQ_WD'(1);
            m_run[ch]++;
            if (m_run[ch] == LOSS_THR) begin
              m_lock[ch] = 1'b0;
              m_run[ch]  = 0;
            end
          end
        end
      end
      if (found) m_fe_vld = 1'b1;
    end

    for (int ch = 0; ch < CH_NUM; ch++) begin
      e.suc[ch]  = CNT_WD'(m_suc[ch]);
      e.err[ch]  = CNT_WD'(m_err[ch]);
      e.lock[ch] = m_lock[ch];
    end
    e.fe_vld = m_fe_vld;
    e.fe_ch  = 4'(m_fe_ch);
    e.fe_exp = m_fe_exp;
    e.fe_rcv = m_fe_rcv;
    sb_q.push_back(e);

    @(posedge clk);
    @(negedge clk);

    got.suc    = suc_cnt;
    got.err    = err_cnt;
    got.lock   = lock;
    got.fe_vld = first_err_vld;
    got.fe_ch  = first_err_ch;
    got.fe_exp = first_err_exp;
    got.fe_rcv = first_err_rcv;

    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL sb_empty: no expected snapshot queued at %0t", $time);
    end else begin
      e = sb_q.pop_front();
      if (got.suc !== e.suc) begin
        errors++;
        $display("FAIL sb_suc_cnt @%0t: got %h want %h", $time, got.suc, e.suc);
      end
      checks++;
      if (got.err !== e.err) begin
        errors++;
        $display("FAIL sb_err_cnt @%0t: got %h want %h", $time, got.err, e.err);
      end
      checks++;
      if (got.lock !== e.lock) begin
        errors++;
        $display("FAIL sb_lock @%0t: got %b want %b", $time, got.lock, e.lock);
      end
      checks++;
      if ({got.fe_vld, got.fe_ch, got.fe_exp, got.fe_rcv} !==
          {e.fe_vld, e.fe_ch, e.fe_exp, e.fe_rcv}) begin
        errors++;
        $display("FAIL sb_first_err @%0t: got vld=%b ch=%0d exp=%h rcv=%h want vld=%b ch=%0d exp=%h rcv=%h",
                 $time, got.fe_vld, got.fe_ch, got.fe_exp, got.fe_rcv,
                 e.fe_vld, e.fe_ch, e.fe_exp, e.fe_rcv);
      end
    end

    enc_vld = '0;
    cfg_rst = 1'b0;
  endtask

  task automatic send(input int ch, input logic [SEQ_WD-1:0] s);
    logic [CH_NUM-1:0]             vld;
    logic [CH_NUM-1:0][SEQ_WD-1:0] seq;
    vld     = '0;
    seq     = '0;
    vld[ch] = 1'b1;
    seq[ch] = s;
    cycle(vld, seq, 1'b0);
  endtask

  task automatic clear_all();
    cycle('0, '0, 1'b1);
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    cfg_rst = 1'b0;
    enc_vld = '1;
    enc_data = {CH_NUM*DATA_WD/32{$urandom}};
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (suc_cnt !== '0 || err_cnt !== '0) begin
      errors++;
      $display("FAIL reset_counters: suc=%h err=%h want 0", suc_cnt, err_cnt);
    end
    checks++;
    if (lock !== '0) begin
      errors++;
      $display("FAIL reset_lock: got %b want 0", lock);
    end
    checks++;
    if ({first_err_vld, first_err_ch, first_err_exp, first_err_rcv} !== '0) begin
      errors++;
      $display("FAIL reset_first_err: vld=%b ch=%0d exp=%h rcv=%h want all 0",
               first_err_vld, first_err_ch, first_err_exp, first_err_rcv);
    end
    enc_vld = '0;
    rst_n   = 1'b1;
    model_clear();
    @(negedge clk);
  endtask

  task automatic test_basic_lock();
    clear_all();
    cfg_resync = 1'b0;
    send(0, 16'd5);
    checks++;
    if (lock[0] !== 1'b1) begin
      errors++;
      $display("FAIL basic_lock_rise: got %b want 1", lock[0]);
    end
    send(0, 16'd6);
    send(0, 16'd7);
    send(0, 16'd8);
    checks++;
    if (suc_of(0) !== 4'd3 || err_of(0) !== 4'd0) begin
      errors++;
      $display("FAIL basic_counts: suc=%0d err=%0d want 3/0", suc_of(0), err_of(0));
    end
    checks++;
    if (first_err_vld !== 1'b0) begin
      errors++;
      $display("FAIL basic_first_err: got %b want 0", first_err_vld);
    end
  endtask

  task automatic test_wrap();
    clear_all();
    send(1, 16'hFFFE);
    send(1, 16'hFFFF);
    send(1, 16'h0000);
    send(1, 16'h0001);
    checks++;
    if (suc_of(1) !== 4'd3 || err_of(1) !== 4'd0) begin
      errors++;
      $display("FAIL wrap_counts: suc=%0d err=%0d want 3/0", suc_of(1), err_of(1));
    end
  endtask

  task automatic test_strict_resync();
    logic [SEQ_WD-1:0] pat [5];
    pat = '{16'd10, 16'd11, 16'd20, 16'd21, 16'd22};
    clear_all();
    cfg_resync = 1'b0;
    for (int i = 0; i < 5; i++) send(2, pat[i]);
    checks++;
    if (err_of(2) !== 4'd3 || suc_of(2) !== 4'd1 || lock[2] !== 1'b1) begin
      errors++;
      $display("FAIL strict_counts: err=%0d suc=%0d lock=%b want 3/1/1", err_of(2), suc_of(2), lock[2]);
    end
    clear_all();
    cfg_resync = 1'b1;
    for (int i = 0; i < 5; i++) send(2, pat[i]);
    checks++;
    if (err_of(2) !== 4'd1 || suc_of(2) !== 4'd3) begin
      errors++;
      $display("FAIL resync_counts: err=%0d suc=%0d want 1/3", err_of(2), suc_of(2));
    end
    cfg_resync = 1'b0;
  endtask

  task automatic test_loss_of_lock();
    clear_all();
    cfg_resync = 1'b0;
    send(0, 16'h0000);
    for (int i = 0; i < 3; i++) send(0, 16'h0100);
    checks++;
    if (lock[0] !== 1'b1) begin
      errors++;
      $display("FAIL loss_held_at_3: lock=%b want 1", lock[0]);
    end
    send(0, 16'h0100);
    checks++;
    if (err_of(0) !== 4'd4 || lock[0] !== 1'b0) begin
      errors++;
      $display("FAIL loss_drop: err=%0d lock=%b want 4/0", err_of(0), lock[0]);
    end
    send(0, 16'h0200);
    checks++;
    if (lock[0] !== 1'b1 || suc_of(0) !== 4'd0 || err_of(0) !== 4'd4) begin
      errors++;
      $display("FAIL loss_relock: lock=%b suc=%0d err=%0d want 1/0/4", lock[0], suc_of(0), err_of(0));
    end
    send(0, 16'h0201);
    checks++;
    if (suc_of(0) !== 4'd1) begin
      errors++;
      $display("FAIL loss_after_relock: suc=%0d want 1", suc_of(0));
    end
  endtask

  task automatic test_first_error();
    logic [CH_NUM-1:0][SEQ_WD-1:0] seq;
    clear_all();
    cfg_resync = 1'b0;
    seq    = '0;
    seq[0] = 16'd0;
    seq[1] = 16'd6;
    seq[3] = 16'd100;
    cycle(4'b1011, seq, 1'b0);
    seq[0] = 16'd1;
    seq[1] = 16'd9;
    seq[3] = 16'd50;
    cycle(4'b1011, seq, 1'b0);
    checks++;
    if (first_err_vld !== 1'b1 || first_err_ch !== 4'd1 ||
        first_err_exp !== 16'd7 || first_err_rcv !== 16'd9) begin
      errors++;
      $display("FAIL first_err_tie: vld=%b ch=%0d exp=%0d rcv=%0d want 1/1/7/9",
               first_err_vld, first_err_ch, first_err_exp, first_err_rcv);
    end
    send(0, 16'd99);
    checks++;
    if (err_of(0) !== 4'd1 || first_err_ch !== 4'd1 ||
        first_err_exp !== 16'd7 || first_err_rcv !== 16'd9) begin
      errors++;
      $display("FAIL first_err_sticky: err0=%0d ch=%0d exp=%0d rcv=%0d want 1/1/7/9",
               err_of(0), first_err_ch, first_err_exp, first_err_rcv);
    end
  endtask

  task automatic test_sat_clear();
    logic [SEQ_WD-1:0]             s;
    logic [CH_NUM-1:0][SEQ_WD-1:0] seq;
    clear_all();
    cfg_resync = 1'b1;
    s = 16'd0;
    send(2, s);
    for (int i = 0; i < 17; i++) begin
      send(2, s + 16'd3);
      send(2, s + 16'd4);
      s = s + 16'd4;
      if (i == 13) begin
        checks++;
        if (err_of(2) !== 4'd14) begin
          errors++;
          $display("FAIL sat_preload: err=%0d want 14", err_of(2));
        end
      end
    end
    checks++;
    if (err_of(2) !== 4'd15 || suc_of(2) !== 4'd15) begin
      errors++;
      $display("FAIL sat_hold: err=%0d suc=%0d want 15/15", err_of(2), suc_of(2));
    end
    seq    = '0;
    seq[2] = 16'd99;
    cycle('1, seq, 1'b1);
    checks++;
    if (suc_cnt !== '0 || err_cnt !== '0 || lock !== '0 || first_err_vld !== 1'b0) begin
      errors++;
      $display("FAIL clear_all_zero: suc=%h err=%h lock=%b fev=%b want 0",
               suc_cnt, err_cnt, lock, first_err_vld);
    end
    send(2, 16'd100);
    checks++;
    if (lock[2] !== 1'b1 || suc_of(2) !== 4'd0) begin
      errors++;
      $display("FAIL clear_vld_dropped: lock=%b suc=%0d want 1/0", lock[2], suc_of(2));
    end
    send(2, 16'd101);
    checks++;
    if (suc_of(2) !== 4'd1) begin
      errors++;
      $display("FAIL clear_relock_count: suc=%0d want 1", suc_of(2));
    end
    cfg_resync = 1'b0;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    cfg_rst    = 1'b0;
    cfg_resync = 1'b0;
    enc_vld    = '0;
    enc_data   = '0;
    model_clear();

    test_reset();
    test_basic_lock();
    test_wrap();
    test_strict_resync();
    test_loss_of_lock();
    test_first_error();
    test_sat_clear();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
